// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle shared by the UART bridge command master and its slaves.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Turns one decoded UART bridge command into a single AXI4-Lite transaction with a
// per-transaction timeout, and hands data plus a status code back to the frame builder.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEFAULT_TIMEOUT = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [7:0]              rsp_status,
  input  logic [7:0]              timeout_config,
  output logic                    busy,
  axi4_lite_if.master             axi
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA, RESP} state_t;

  state_t                  state, state_n;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_n;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_n;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_n;
  logic [15:0]             limit_q, limit_n;
  logic [15:0]             cnt_q, cnt_n;
  logic                    awvalid_q, awvalid_n, wvalid_q, wvalid_n, bready_q, bready_n;
  logic                    arvalid_q, arvalid_n, rready_q, rready_n;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_n;
  logic [7:0]              status_q, status_n;
  logic                    aw_hs, w_hs, expire, take_timeout;

  function automatic logic [7:0] map_resp(input logic [1:0] resp);
    case (resp)
      2'b00:   map_resp = 8'h00;
      2'b10:   map_resp = 8'h01;
      2'b11:   map_resp = 8'h02;
      default: map_resp = 8'h03;
    endcase
  endfunction

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_rdata   = rdata_q;
  assign rsp_status  = status_q;
  assign axi.awaddr  = addr_q;
  assign axi.araddr  = addr_q;
  assign axi.awprot  = 3'b000;
  assign axi.arprot  = 3'b000;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.awvalid = awvalid_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign aw_hs  = awvalid_q & axi.awready;
  assign w_hs   = wvalid_q & axi.wready;
  // One cycle early so the channel drops on the edge where the count reaches the limit.
  assign expire = ({1'b0, cnt_q} + 17'd1) >= {1'b0, limit_q};

  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    wstrb_n      = wstrb_q;
    limit_n      = limit_q;
    cnt_n        = cnt_q;
    awvalid_n    = awvalid_q;
    wvalid_n     = wvalid_q;
    bready_n     = bready_q;
    arvalid_n    = arvalid_q;
    rready_n     = rready_q;
    rdata_n      = rdata_q;
    status_n     = status_q;
    take_timeout = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          addr_n  = cmd_addr;
          wdata_n = cmd_wdata;
          wstrb_n = cmd_wstrb;
          cnt_n   = 16'd0;
          limit_n = (timeout_config == 8'd0) ? 16'(DEFAULT_TIMEOUT) : {4'h0, timeout_config, 4'h0};
          if (cmd_write) begin
            state_n   = WR;
            awvalid_n = 1'b1;
            wvalid_n  = 1'b1;
          end else begin
            state_n   = RD;
            arvalid_n = 1'b1;
          end
        end
      end
      WR: begin
        cnt_n = cnt_q + 16'd1;
        if (aw_hs) awvalid_n = 1'b0;
        if (w_hs)  wvalid_n  = 1'b0;
        if ((!awvalid_q || aw_hs) && (!wvalid_q || w_hs)) begin
          state_n  = WRESP;
          bready_n = 1'b1;
        end else if (expire && !aw_hs && !w_hs) begin
          take_timeout = 1'b1;
        end
      end
      WRESP: begin
        cnt_n = cnt_q + 16'd1;
        if (axi.bvalid) begin
          bready_n = 1'b0;
          rdata_n  = '0;
          status_n = map_resp(axi.bresp);
          state_n  = RESP;
        end else if (expire) begin
          take_timeout = 1'b1;
        end
      end
      RD: begin
        cnt_n = cnt_q + 16'd1;
        if (axi.arready) begin
          arvalid_n = 1'b0;
          state_n   = RDATA;
        end else if (expire) begin
          take_timeout = 1'b1;
        end
      end
      RDATA: begin
        cnt_n    = cnt_q + 16'd1;
        rready_n = 1'b1;
        if (rready_q && axi.rvalid) begin
          rready_n = 1'b0;
          rdata_n  = axi.rdata;
          status_n = map_resp(axi.rresp);
          state_n  = RESP;
        end else if (expire) begin
          take_timeout = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (take_timeout) begin
      awvalid_n = 1'b0;
      wvalid_n  = 1'b0;
      bready_n  = 1'b0;
      arvalid_n = 1'b0;
      rready_n  = 1'b0;
      rdata_n   = '0;
      status_n  = 8'h04;
      state_n   = RESP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      limit_q   <= '0;
      cnt_q     <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      status_q  <= '0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      wdata_q   <= wdata_n;
      wstrb_q   <= wstrb_n;
      limit_q   <= limit_n;
      cnt_q     <= cnt_n;
      awvalid_q <= awvalid_n;
      wvalid_q  <= wvalid_n;
      bready_q  <= bready_n;
      arvalid_q <= arvalid_n;
      rready_q  <= rready_n;
      rdata_q   <= rdata_n;
      status_q  <= status_n;
    end
  end
endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: a configurable-latency AXI4-Lite slave plus a
// transaction-level model predicting status, read data and response latency.
module tb_axi_lite_cmd_master;
  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [7:0]  rsp_status;
  logic [7:0]  timeout_config;
  logic        busy;

  axi4_lite_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) axi_bus ();

  axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEFAULT_TIMEOUT(4096)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_status(rsp_status), .timeout_config(timeout_config), .busy(busy),
    .axi(axi_bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Slave behaviour knobs: cycles of wait before each ready/valid, and response codes.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'h0;

  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  logic aw_seen, w_seen, b_pending, r_pending;
  int aw_beats, w_beats, ar_beats, w_unstable;
  logic [31:0] last_awaddr, last_wdata, last_araddr, exp_wdata;
  logic [3:0]  last_wstrb, exp_wstrb;
  logic [2:0]  last_awprot, last_arprot;

  logic [7:0] resp_status [4] = '{8'h00, 8'h03, 8'h01, 8'h02};

  // Slave drives its outputs on the falling edge so the DUT sees them settled.
  always @(negedge clk) begin
    if (rst) begin
      axi_bus.awready = 1'b0; axi_bus.wready = 1'b0; axi_bus.arready = 1'b0;
      axi_bus.bvalid  = 1'b0; axi_bus.rvalid = 1'b0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      if (axi_bus.awvalid) begin axi_bus.awready = (aw_cnt >= aw_lat); aw_cnt++; end
      else begin axi_bus.awready = 1'b0; aw_cnt = 0; end
      if (axi_bus.wvalid) begin axi_bus.wready = (w_cnt >= w_lat); w_cnt++; end
      else begin axi_bus.wready = 1'b0; w_cnt = 0; end
      if (axi_bus.arvalid) begin axi_bus.arready = (ar_cnt >= ar_lat); ar_cnt++; end
      else begin axi_bus.arready = 1'b0; ar_cnt = 0; end
      if (b_pending) begin
        if (b_cnt >= b_lat) axi_bus.bvalid = 1'b1; else b_cnt++;
      end else begin axi_bus.bvalid = 1'b0; b_cnt = 0; end
      if (r_pending) begin
        if (r_cnt >= r_lat) axi_bus.rvalid = 1'b1; else r_cnt++;
      end else begin axi_bus.rvalid = 1'b0; r_cnt = 0; end
    end
    axi_bus.bresp = bresp_cfg;
    axi_bus.rresp = rresp_cfg;
    axi_bus.rdata = rdata_cfg;
  end

  // Handshake monitor: counts beats, records what was transferred, arms responses.
  always @(posedge clk) begin
    if (rst) begin
      aw_seen = 1'b0; w_seen = 1'b0; b_pending = 1'b0; r_pending = 1'b0;
    end else begin
      if (axi_bus.awvalid && axi_bus.awready) begin
        aw_beats++; last_awaddr = axi_bus.awaddr; last_awprot = axi_bus.awprot; aw_seen = 1'b1;
      end
      if (axi_bus.wvalid && (axi_bus.wdata !== exp_wdata || axi_bus.wstrb !== exp_wstrb)) w_unstable++;
      if (axi_bus.wvalid && axi_bus.wready) begin
        w_beats++; last_wdata = axi_bus.wdata; last_wstrb = axi_bus.wstrb; w_seen = 1'b1;
      end
      if (aw_seen && w_seen) begin b_pending = 1'b1; aw_seen = 1'b0; w_seen = 1'b0; end
      if (axi_bus.bvalid && axi_bus.bready) b_pending = 1'b0;
      if (axi_bus.arvalid && axi_bus.arready) begin
        ar_beats++; last_araddr = axi_bus.araddr; last_arprot = axi_bus.arprot; r_pending = 1'b1;
      end
      if (axi_bus.rvalid && axi_bus.rready) r_pending = 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Issues one command and waits (bounded) for the response; latency counts from the accept cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s, output int lat, output int ar_cycles);
    @(negedge clk);
    aw_beats = 0; w_beats = 0; ar_beats = 0; w_unstable = 0;
    aw_seen = 1'b0; w_seen = 1'b0;
    exp_wdata = d; exp_wstrb = s;
    checkOutput("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("busy_after_accept", {62'd0, busy, cmd_ready}, 64'd2);
    lat = 1;
    ar_cycles = 0;
    while (!rsp_valid && lat < 400) begin
      if (axi_bus.arvalid) ar_cycles++;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = -1;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checkOutput("released_cmd_ready", {62'd0, cmd_ready, rsp_valid}, 64'd2);
  endtask

  task automatic runTxn(input string tag, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s, input int hold);
    int lat, arc, exp_lat;
    logic [7:0]  exp_status;
    logic [31:0] exp_rdata;
    exp_status = wr ? resp_status[bresp_cfg] : resp_status[rresp_cfg];
    exp_rdata  = wr ? 32'd0 : rdata_cfg;
    exp_lat    = wr ? 3 + max2(aw_lat, w_lat) + b_lat : ar_lat + max2(4, 3 + r_lat);
    applyStimulus(wr, a, d, s, lat, arc);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    checkOutput({tag, ".status"}, {56'd0, rsp_status}, {56'd0, exp_status});
    checkOutput({tag, ".rdata"}, {32'd0, rsp_rdata}, {32'd0, exp_rdata});
    if (wr) begin
      checkOutput({tag, ".aw_beats"}, 64'(aw_beats), 64'd1);
      checkOutput({tag, ".w_beats"}, 64'(w_beats), 64'd1);
      checkOutput({tag, ".ar_beats"}, 64'(ar_beats), 64'd0);
      checkOutput({tag, ".awaddr"}, {32'd0, last_awaddr}, {32'd0, a});
      checkOutput({tag, ".wdata"}, {32'd0, last_wdata}, {32'd0, d});
      checkOutput({tag, ".wstrb"}, {60'd0, last_wstrb}, {60'd0, s});
      checkOutput({tag, ".awprot"}, {61'd0, last_awprot}, 64'd0);
      checkOutput({tag, ".w_stable"}, 64'(w_unstable), 64'd0);
    end else begin
      checkOutput({tag, ".ar_beats"}, 64'(ar_beats), 64'd1);
      checkOutput({tag, ".aw_beats"}, 64'(aw_beats), 64'd0);
      checkOutput({tag, ".araddr"}, {32'd0, last_araddr}, {32'd0, a});
      checkOutput({tag, ".arprot"}, {61'd0, last_arprot}, 64'd0);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, {63'd0, rsp_valid}, 64'd1);
      checkOutput({tag, ".hold_status"}, {56'd0, rsp_status}, {56'd0, exp_status});
      checkOutput({tag, ".hold_rdata"}, {32'd0, rsp_rdata}, {32'd0, exp_rdata});
    end
    consume();
  endtask

  initial begin
    int lat, arc;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0; timeout_config = 8'd8;
    exp_wdata = '0; exp_wstrb = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset.cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("reset.rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("reset.busy", {63'd0, busy}, 64'd0);
    checkOutput("reset.rsp_rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("reset.rsp_status", {56'd0, rsp_status}, 64'd0);
    checkOutput("reset.axi_handshakes",
                {59'd0, axi_bus.awvalid, axi_bus.wvalid, axi_bus.bready, axi_bus.arvalid, axi_bus.rready}, 64'd0);
    rst = 1'b0;

    $display("[TB] zero-wait write and read");
    runTxn("wr_basic", 1'b1, 32'h1000, 32'h0000_0001, 4'hF, 0);
    rdata_cfg = 32'h0001_0000;
    runTxn("rd_basic", 1'b0, 32'h101C, 32'h0, 4'h0, 0);

    $display("[TB] W accepted one cycle after AW");
    w_lat = 1;
    runTxn("wr_wlate", 1'b1, 32'h1008, 32'hA5A5_5A5A, 4'hF, 0);
    w_lat = 0;

    $display("[TB] slave error responses");
    rresp_cfg = 2'b10; rdata_cfg = 32'h1234_5678;
    runTxn("rd_slverr", 1'b0, 32'h1020, 32'h0, 4'h0, 0);
    rresp_cfg = 2'b00; bresp_cfg = 2'b10;
    runTxn("wr_slverr", 1'b1, 32'h1004, 32'hCAFE_F00D, 4'h6, 0);
    bresp_cfg = 2'b11;
    runTxn("wr_decerr", 1'b1, 32'h2000, 32'h0BAD_0BAD, 4'h3, 0);
    bresp_cfg = 2'b00; rresp_cfg = 2'b01;
    runTxn("rd_exokay", 1'b0, 32'h1010, 32'h0, 4'h0, 0);
    rresp_cfg = 2'b00;

    $display("[TB] read timeout");
    timeout_config = 8'd2; ar_lat = 9999; rdata_cfg = 32'hDEAD_BEEF;
    applyStimulus(1'b0, 32'h1030, 32'h0, 4'h0, lat, arc);
    checkOutput("timeout.arvalid_cycles", 64'(arc), 64'd32);
    checkOutput("timeout.latency", 64'(lat), 64'd33);
    checkOutput("timeout.status", {56'd0, rsp_status}, 64'h04);
    checkOutput("timeout.rdata", {32'd0, rsp_rdata}, 64'd0);
    checkOutput("timeout.arvalid_low", {63'd0, axi_bus.arvalid}, 64'd0);
    consume();
    ar_lat = 0; timeout_config = 8'd8;

    $display("[TB] randomized transactions");
    for (int n = 0; n < 16; n++) begin
      logic wr;
      wr = 1'($urandom_range(0, 1));
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3);
      ar_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      bresp_cfg = 2'($urandom_range(0, 3)); rresp_cfg = 2'($urandom_range(0, 3));
      rdata_cfg = $urandom;
      runTxn("rnd", wr, {$urandom} & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
             $urandom_range(0, 2));
    end
    aw_lat = 0; w_lat = 0; ar_lat = 0; b_lat = 0; r_lat = 0; bresp_cfg = 2'b00; rresp_cfg = 2'b00;

    $display("[TB] response held while rsp_ready low, then reset mid-write");
    runTxn("wr_hold", 1'b1, 32'h1040, 32'h5555_AAAA, 4'h9, 10);
    aw_lat = 9999; w_lat = 9999;
    @(negedge clk);
    exp_wdata = 32'h7777_1111; exp_wstrb = 4'hF;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h1044; cmd_wdata = 32'h7777_1111; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset.awvalid", {63'd0, axi_bus.awvalid}, 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    aw_lat = 0; w_lat = 0;
    checkOutput("post_reset.cmd_ready", {63'd0, cmd_ready}, 64'd1);
    checkOutput("post_reset.busy", {63'd0, busy}, 64'd0);
    checkOutput("post_reset.axi_valids", {62'd0, axi_bus.awvalid, axi_bus.wvalid}, 64'd0);
    repeat (5) begin
      @(negedge clk);
      checkOutput("post_reset.no_rsp", {63'd0, rsp_valid}, 64'd0);
    end
    runTxn("wr_after_reset", 1'b1, 32'h1048, 32'h0000_00FF, 4'h1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
